parking_keypad_entry: RTL and testbench
=======================================

Name: parking_keypad_entry

Overview:
Driver-side keypad front end for the parking controller; it produces the password_input code that the controller consumes.
- Starts a session when a car triggers entrance_sensor.
- Debounces the raw keypad digit, enter and clear keys, and builds a 4-bit code.
- Presents the code with a one-cycle valid strobe, then waits for the controller's accept/reject verdict.
- Enforces an entry timeout, an attempt limit and a lockout period.

Parameters:
- DEBOUNCE_CYCLES, 4: consecutive high samples required to register one key press.
- TIMEOUT_CYCLES, 20: idle cycles allowed in ENTRY or WAIT_RESULT before the session is abandoned.
- MAX_ATTEMPTS, 3: rejected codes allowed before lockout (range 1..3).
- LOCKOUT_CYCLES, 50: lockout duration in cycles.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- entrance_sensor  in  1  car-present level; starts a session.
- key_raw  in  1  raw digit-key contact.
- key_value  in  4  digit value, sampled when the digit press registers.
- enter_raw  in  1  raw enter-key contact.
- clear_raw  in  1  raw clear-key contact.
- result_valid  in  1  one-cycle verdict strobe from the controller.
- result_ok  in  1  verdict; meaningful only while result_valid=1.
- password_input  out  4  code presented to the controller.
- password_valid  out  1  one-cycle strobe qualifying password_input.
- prompt  out  1  high while ENTRY.
- locked  out  1  high while LOCKOUT.
- entry_timeout  out  1  one-cycle pulse when a session times out.
- attempts_left  out  2  remaining attempts.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; this is already decided.
- Reset state:
  - FSM=IDLE.
  - password_input=0, password_valid=0, prompt=0, locked=0, entry_timeout=0.
  - attempts_left=MAX_ATTEMPTS.
  - Code register=0, digit_seen=0, all counters=0.
- Debounce (per key):
  - A stability counter increments while the raw input is high and clears when it is low.
  - A one-cycle press pulse is generated on the edge where the count reaches DEBOUNCE_CYCLES.
  - No further press is generated until the raw input has been sampled low.
  - The FSM acts on the press at the next edge.
  - Overall latency: a key first sampled high at edge N takes effect at edge N+DEBOUNCE_CYCLES.
- Simultaneous presses: priority is clear > enter > digit; lower-priority presses in the same cycle are dropped.
- FSM states: IDLE, ENTRY, WAIT_RESULT, LOCKOUT.
- IDLE:
  - entrance_sensor=1 → ENTRY; code cleared, digit_seen=0, timer=0.
  - All key presses are ignored.
- ENTRY (prompt=1):
  - Digit press: code<=key_value (the last digit wins), digit_seen=1, timer=0.
  - Clear press: code<=0, digit_seen=0, timer=0.
  - Enter press with digit_seen=1: password_input<=code, password_valid=1 for exactly one cycle → WAIT_RESULT, timer=0.
  - Enter press with digit_seen=0: ignored, timer still reset.
  - Timer reaches TIMEOUT_CYCLES with no press → IDLE, entry_timeout pulses one cycle, attempts_left reloads.
- WAIT_RESULT:
  - password_input is held and keys are ignored.
  - result_valid with result_ok=1 → IDLE; password_input<=0, attempts_left reloads.
  - result_valid with result_ok=0, attempts_left>1 → decrement, return to ENTRY; password_input<=0, code cleared.
  - result_valid with result_ok=0, attempts_left==1 → attempts_left=0, LOCKOUT, lockout counter=0.
  - result_valid arriving on the same edge that password_valid rises is legal and is processed.
  - Timer reaches TIMEOUT_CYCLES with no verdict → IDLE with an entry_timeout pulse.
- LOCKOUT:
  - locked=1; keys and entrance_sensor are ignored.
  - After LOCKOUT_CYCLES → IDLE, attempts_left=MAX_ATTEMPTS.
- password_input is 0 in every state except the valid cycle and WAIT_RESULT.
- Any result_valid outside WAIT_RESULT is ignored.
- Reset asserted mid-operation returns to the reset state at that edge; a pending strobe is dropped.
- All counters saturate and never wrap.

Optional Feature:
- Macro: PARKING_KEYPAD_ECHO_EN.
- When defined:
  - Adds output echo_display[6:0]: active-high segments {g,f,e,d,c,b,a} showing the current code as a hex glyph while in ENTRY with digit_seen=1.
  - echo_display is 0 otherwise and on reset.
  - The value is registered and updates one cycle after the code changes.
- When undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package parking_pkg:
  - FSM state enum.
  - Default parameter constants.
  - Hex-to-7-segment function, shared with the controller's display.
- Sub-module keypad_debouncer (parameter DEBOUNCE_CYCLES; ports clock, reset, raw, press), instanced three times.

Test Plan:
- Reset, entrance_sensor pulse, digit 4'b1101 held 6 cycles, enter held 6 cycles → password_valid exactly one cycle with password_input=4'b1101, 4 cycles after enter is first sampled high; result_valid/result_ok=1 → IDLE, password_input=0.
- Digit key held only 3 cycles, then 4'b1010 held 5 cycles → code=4'b1010; the bounce registers no press; a single long hold yields exactly one press.
- Three rejections (result_ok=0) → attempts_left 3→2→1→0, locked=1 for 50 cycles, entrance_sensor ignored during lockout, then IDLE with attempts_left=3.
- ENTRY with no key for 20 cycles → entry_timeout one-cycle pulse, state IDLE, prompt=0; enter with no digit → no password_valid.
- Digit 4'b0111 and clear registered on the same cycle, followed by enter → clear wins and enter is ignored (digit_seen=0); reset asserted during WAIT_RESULT → all outputs return to reset values at that edge.
- With PARKING_KEYPAD_ECHO_EN defined, digit 4'b0011 → echo_display=7'b1001111 one cycle after the code update; 0 after reset.

Source files
------------

// File: rtl/parking_pkg.sv
// Shared types, default constants and the hex-to-7-segment helper for the parking keypad front end.
package parking_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_ENTRY       = 2'd1,
        ST_WAIT_RESULT = 2'd2,
        ST_LOCKOUT     = 2'd3
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_TIMEOUT_CYCLES  = 20;
    localparam int DEF_MAX_ATTEMPTS    = 3;
    localparam int DEF_LOCKOUT_CYCLES  = 50;

    // Active-high segments ordered {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        seg = 7'b0000000;
        case (hex)
            4'h0: seg = 7'b0111111;
            4'h1: seg = 7'b0000110;
            4'h2: seg = 7'b1011011;
            4'h3: seg = 7'b1001111;
            4'h4: seg = 7'b1100110;
            4'h5: seg = 7'b1101101;
            4'h6: seg = 7'b1111101;
            4'h7: seg = 7'b0000111;
            4'h8: seg = 7'b1111111;
            4'h9: seg = 7'b1101111;
            4'ha: seg = 7'b1110111;
            4'hb: seg = 7'b1111100;
            4'hc: seg = 7'b0111001;
            4'hd: seg = 7'b1011110;
            4'he: seg = 7'b1111001;
            4'hf: seg = 7'b1110001;
            default: seg = 7'b0000000;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/parking_keypad_entry_if.sv
// Code hand-off between the keypad front end (master) and the parking controller (slave).
// password_valid is a one-cycle strobe qualifying password_input; the controller answers
// later with a one-cycle result_valid strobe, and result_ok is meaningful only in that cycle.
interface parking_keypad_entry_if;
    logic [3:0] password_input;
    logic       password_valid;
    logic       result_valid;
    logic       result_ok;

    modport master (
        output password_input,
        output password_valid,
        input  result_valid,
        input  result_ok
    );

    modport slave (
        input  password_input,
        input  password_valid,
        output result_valid,
        output result_ok
    );
endinterface

// File: rtl/keypad_debouncer.sv
// Single-key debouncer: one press pulse after DEBOUNCE_CYCLES consecutive high samples,
// re-armed only once the raw contact has been sampled low.
module keypad_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic press
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_FIRE = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt;

    // The count saturates at CNT_MAX, so CNT_FIRE is crossed once per high period.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt   <= '0;
            press <= 1'b0;
        end else if (raw) begin
            if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            press <= (cnt == CNT_FIRE);
        end else begin
            cnt   <= '0;
            press <= 1'b0;
        end
    end
endmodule

// File: rtl/parking_keypad_entry.sv
// Driver-side keypad front end: session start, code entry, verdict wait, timeout and lockout.
// Optional macro PARKING_KEYPAD_ECHO_EN adds a registered 7-segment echo of the entered code.
module parking_keypad_entry
    import parking_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
    parameter int MAX_ATTEMPTS    = DEF_MAX_ATTEMPTS,
    parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        entrance_sensor,
    input  logic        key_raw,
    input  logic [3:0]  key_value,
    input  logic        enter_raw,
    input  logic        clear_raw,
    parking_keypad_entry_if.master bus,
    output logic        prompt,
    output logic        locked,
    output logic        entry_timeout,
    output logic [1:0]  attempts_left,
`ifdef PARKING_KEYPAD_ECHO_EN
    output logic [6:0]  echo_display,
`endif
    output state_t      state_dbg
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [1:0]    ATT_MAX    = 2'(MAX_ATTEMPTS);

    state_t        state;
    logic [3:0]    code;
    logic          digit_seen;
    logic [TW-1:0] timer;
    logic [LW-1:0] lock_cnt;
    logic          digit_press, enter_press, clear_press;

    keypad_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_digit_db (
        .clock(clock), .reset(reset), .raw(key_raw),   .press(digit_press));
    keypad_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_db (
        .clock(clock), .reset(reset), .raw(enter_raw), .press(enter_press));
    keypad_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
        .clock(clock), .reset(reset), .raw(clear_raw), .press(clear_press));

    assign state_dbg = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= ST_IDLE;
            code               <= 4'd0;
            digit_seen         <= 1'b0;
            timer              <= '0;
            lock_cnt           <= '0;
            bus.password_input <= 4'd0;
            bus.password_valid <= 1'b0;
            prompt             <= 1'b0;
            locked             <= 1'b0;
            entry_timeout      <= 1'b0;
            attempts_left      <= ATT_MAX;
        end else begin
            bus.password_valid <= 1'b0;
            entry_timeout      <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (entrance_sensor) begin
                        state      <= ST_ENTRY;
                        prompt     <= 1'b1;
                        code       <= 4'd0;
                        digit_seen <= 1'b0;
                        timer      <= '0;
                    end
                end
                ST_ENTRY: begin
                    // Priority clear > enter > digit; lower presses in the same cycle are lost.
                    if (clear_press) begin
                        code       <= 4'd0;
                        digit_seen <= 1'b0;
                        timer      <= '0;
                    end else if (enter_press) begin
                        timer <= '0;
                        if (digit_seen) begin
                            bus.password_input <= code;
                            bus.password_valid <= 1'b1;
                            state              <= ST_WAIT_RESULT;
                            prompt             <= 1'b0;
                        end
                    end else if (digit_press) begin
                        code       <= key_value;
                        digit_seen <= 1'b1;
                        timer      <= '0;
                    end else if (timer == TIMER_LAST) begin
                        state         <= ST_IDLE;
                        prompt        <= 1'b0;
                        entry_timeout <= 1'b1;
                        attempts_left <= ATT_MAX;
                        timer         <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_WAIT_RESULT: begin
                    if (bus.result_valid) begin
                        bus.password_input <= 4'd0;
                        timer              <= '0;
                        if (bus.result_ok) begin
                            state         <= ST_IDLE;
                            attempts_left <= ATT_MAX;
                        end else if (attempts_left > 2'd1) begin
                            attempts_left <= attempts_left - 2'd1;
                            state         <= ST_ENTRY;
                            prompt        <= 1'b1;
                            code          <= 4'd0;
                            digit_seen    <= 1'b0;
                        end else begin
                            attempts_left <= 2'd0;
                            state         <= ST_LOCKOUT;
                            locked        <= 1'b1;
                            lock_cnt      <= '0;
                        end
                    end else if (timer == TIMER_LAST) begin
                        state              <= ST_IDLE;
                        bus.password_input <= 4'd0;
                        entry_timeout      <= 1'b1;
                        attempts_left      <= ATT_MAX;
                        timer              <= '0;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                ST_LOCKOUT: begin
                    if (lock_cnt == LOCK_LAST) begin
                        state         <= ST_IDLE;
                        locked        <= 1'b0;
                        attempts_left <= ATT_MAX;
                        lock_cnt      <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef PARKING_KEYPAD_ECHO_EN
    always_ff @(posedge clock) begin
        if (reset)
            echo_display <= 7'd0;
        else if (state == ST_ENTRY && digit_seen)
            echo_display <= hex_to_seg(code);
        else
            echo_display <= 7'd0;
    end
`endif

endmodule

// File: tb/tb_parking_keypad_entry.sv
// Directed bench for parking_keypad_entry: entry, debounce, rejections/lockout, timeout,
// clear priority and mid-wait reset; echo display checked when PARKING_KEYPAD_ECHO_EN is set.
module tb_parking_keypad_entry;
    import parking_pkg::*;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       entrance_sensor = 1'b0;
    logic       key_raw = 1'b0;
    logic [3:0] key_value = 4'd0;
    logic       enter_raw = 1'b0;
    logic       clear_raw = 1'b0;
    logic       prompt, locked, entry_timeout;
    logic [1:0] attempts_left;
    state_t     state_dbg;
`ifdef PARKING_KEYPAD_ECHO_EN
    logic [6:0] echo_display;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int pv_count = 0;

    parking_keypad_entry_if bus ();

    parking_keypad_entry dut (
        .clock          (clock),
        .reset          (reset),
        .entrance_sensor(entrance_sensor),
        .key_raw        (key_raw),
        .key_value      (key_value),
        .enter_raw      (enter_raw),
        .clear_raw      (clear_raw),
        .bus            (bus),
        .prompt         (prompt),
        .locked         (locked),
        .entry_timeout  (entry_timeout),
        .attempts_left  (attempts_left),
`ifdef PARKING_KEYPAD_ECHO_EN
        .echo_display   (echo_display),
`endif
        .state_dbg      (state_dbg)
    );

    always #5 clock = ~clock;

    // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clock);
        #1;
        if (bus.password_valid) pv_count++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_session();
        entrance_sensor = 1'b1;
        tick();
        entrance_sensor = 1'b0;
    endtask

    // Enter one code, answer with a verdict during the strobe cycle.
    task automatic do_attempt(input logic [3:0] val, input logic ok);
        key_value = val;
        key_raw = 1'b1;
        repeat (5) tick();
        key_raw = 1'b0;
        tick();
        enter_raw = 1'b1;
        repeat (4) tick();
        check("att_pv_early", bus.password_valid, 1'b0);
        tick();
        check("att_pv_strobe", bus.password_valid, 1'b1);
        check("att_pi_code", bus.password_input, val);
        bus.result_valid = 1'b1;
        bus.result_ok = ok;
        tick();
        bus.result_valid = 1'b0;
        bus.result_ok = 1'b0;
        enter_raw = 1'b0;
        check("att_pv_drop", bus.password_valid, 1'b0);
        check("att_pi_clear", bus.password_input, 4'd0);
    endtask

    initial begin
        int pv_before;
        bus.result_valid = 1'b0;
        bus.result_ok = 1'b0;

        // Reset state.
        tick();
        tick();
        reset = 1'b0;
        check("rst_state", state_dbg, ST_IDLE);
        check("rst_pi", bus.password_input, 4'd0);
        check("rst_pv", bus.password_valid, 1'b0);
        check("rst_prompt", prompt, 1'b0);
        check("rst_locked", locked, 1'b0);
        check("rst_timeout", entry_timeout, 1'b0);
        check("rst_attempts", attempts_left, 2'd3);
`ifdef PARKING_KEYPAD_ECHO_EN
        check("rst_echo", echo_display, 7'd0);
`endif

        // Basic accepted code 1101 with a held wait before the verdict.
        start_session();
        check("t1_prompt", prompt, 1'b1);
        check("t1_state_entry", state_dbg, ST_ENTRY);
        key_value = 4'b1101;
        key_raw = 1'b1;
        repeat (6) tick();
        key_raw = 1'b0;
        enter_raw = 1'b1;
        repeat (4) tick();
        check("t1_pv_before_latency", bus.password_valid, 1'b0);
        tick();
        check("t1_pv", bus.password_valid, 1'b1);
        check("t1_pi", bus.password_input, 4'b1101);
        check("t1_state_wait", state_dbg, ST_WAIT_RESULT);
        check("t1_prompt_off", prompt, 1'b0);
        tick();
        check("t1_pv_one_cycle", bus.password_valid, 1'b0);
        check("t1_pi_held", bus.password_input, 4'b1101);
        enter_raw = 1'b0;
        tick();
        bus.result_valid = 1'b1;
        bus.result_ok = 1'b1;
        tick();
        bus.result_valid = 1'b0;
        bus.result_ok = 1'b0;
        check("t1_state_idle", state_dbg, ST_IDLE);
        check("t1_pi_zero", bus.password_input, 4'd0);
        check("t1_attempts", attempts_left, 2'd3);
        check("t1_pv_total", pv_count, 1);

        // Bounce (3 cycles) registers nothing, so enter alone is ignored.
        start_session();
        key_value = 4'b0101;
        key_raw = 1'b1;
        repeat (3) tick();
        key_raw = 1'b0;
        tick();
        pv_before = pv_count;
        enter_raw = 1'b1;
        repeat (6) tick();
        enter_raw = 1'b0;
        tick();
        check("t2_bounce_no_pv", pv_count, pv_before);
        check("t2_still_entry", state_dbg, ST_ENTRY);
        // Rejected 1010 (one strobe from one long enter hold), attempts 3 -> 2.
        pv_before = pv_count;
        do_attempt(4'b1010, 1'b0);
        check("t2_single_press", pv_count, pv_before + 1);
        check("t2_attempts_2", attempts_left, 2'd2);
        check("t2_back_entry", state_dbg, ST_ENTRY);

        // Two more rejections -> lockout.
        do_attempt(4'b0001, 1'b0);
        check("t3_attempts_1", attempts_left, 2'd1);
        check("t3_prompt", prompt, 1'b1);
        do_attempt(4'b0010, 1'b0);
        check("t3_attempts_0", attempts_left, 2'd0);
        check("t3_locked", locked, 1'b1);
        check("t3_state_lock", state_dbg, ST_LOCKOUT);
        check("t3_prompt_off", prompt, 1'b0);
        entrance_sensor = 1'b1;
        key_raw = 1'b1;
        repeat (40) tick();
        entrance_sensor = 1'b0;
        key_raw = 1'b0;
        repeat (8) tick();
        check("t3_still_locked", locked, 1'b1);
        check("t3_ignores_sensor", state_dbg, ST_LOCKOUT);
        tick();
        check("t3_locked_49", locked, 1'b1);
        tick();
        check("t3_unlocked_50", locked, 1'b0);
        check("t3_idle", state_dbg, ST_IDLE);
        check("t3_attempts_reload", attempts_left, 2'd3);
        tick();
        check("t3_stays_idle", state_dbg, ST_IDLE);

        // Entry timeout after 20 idle cycles.
        start_session();
        repeat (19) tick();
        check("t4_prompt_19", prompt, 1'b1);
        check("t4_no_to_19", entry_timeout, 1'b0);
        tick();
        check("t4_to_pulse", entry_timeout, 1'b1);
        check("t4_prompt_off", prompt, 1'b0);
        check("t4_idle", state_dbg, ST_IDLE);
        tick();
        check("t4_to_one_cycle", entry_timeout, 1'b0);

`ifdef PARKING_KEYPAD_ECHO_EN
        // Echo of digit 3 appears one cycle after the code update.
        start_session();
        check("e_echo_blank", echo_display, 7'd0);
        key_value = 4'b0011;
        key_raw = 1'b1;
        repeat (5) tick();
        check("e_echo_not_yet", echo_display, 7'd0);
        tick();
        check("e_echo_3", echo_display, 7'b1001111);
        key_raw = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("e_echo_reset", echo_display, 7'd0);
        check("e_state_reset", state_dbg, ST_IDLE);
`endif

        // Clear beats a simultaneous digit; the following enter is ignored.
        start_session();
        do_attempt(4'b0100, 1'b0);
        check("t5_attempts_2", attempts_left, 2'd2);
        key_value = 4'b0111;
        key_raw = 1'b1;
        clear_raw = 1'b1;
        repeat (5) tick();
        key_raw = 1'b0;
        clear_raw = 1'b0;
        tick();
        pv_before = pv_count;
        enter_raw = 1'b1;
        repeat (6) tick();
        enter_raw = 1'b0;
        tick();
        check("t5_clear_wins", pv_count, pv_before);
        check("t5_still_entry", state_dbg, ST_ENTRY);
        // Reach WAIT_RESULT, then reset mid-wait.
        key_value = 4'b1001;
        key_raw = 1'b1;
        repeat (5) tick();
        key_raw = 1'b0;
        tick();
        enter_raw = 1'b1;
        repeat (5) tick();
        check("t5_pi", bus.password_input, 4'b1001);
        enter_raw = 1'b0;
        tick();
        check("t5_wait", state_dbg, ST_WAIT_RESULT);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_rst_state", state_dbg, ST_IDLE);
        check("t5_rst_pi", bus.password_input, 4'd0);
        check("t5_rst_pv", bus.password_valid, 1'b0);
        check("t5_rst_prompt", prompt, 1'b0);
        check("t5_rst_locked", locked, 1'b0);
        check("t5_rst_timeout", entry_timeout, 1'b0);
        check("t5_rst_attempts", attempts_left, 2'd3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
